// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: AVR port, SNES read port and SRAM pad side.
// slave = arbiter view, master = requester/SRAM-model view.
interface sram_arbiter_if #(
    parameter int ADDR_W = 21
);
    logic              avr_req;
    logic              avr_wr;
    logic [ADDR_W-1:0] avr_addr;
    logic [7:0]        avr_wdata;
    logic [7:0]        avr_rdata;
    logic              avr_ack;
    logic              snes_req;
    logic [ADDR_W-1:0] snes_addr;
    logic [7:0]        snes_rdata;
    logic              snes_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_dout;
    logic [7:0]        sram_din;
    logic              sram_dout_en;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport slave (
        input  avr_req, avr_wr, avr_addr, avr_wdata, snes_req, snes_addr, sram_din,
        output avr_rdata, avr_ack, snes_rdata, snes_ack,
               sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport master (
        output avr_req, avr_wr, avr_addr, avr_wdata, snes_req, snes_addr, sram_din,
        input  avr_rdata, avr_ack, snes_rdata, snes_ack,
               sram_addr, sram_dout, sram_dout_en, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter (AVR read/write, SNES read-only) with a fixed
// SETUP/STROBE/RELEASE access cycle. ARB_ROUND_ROBIN_EN enables fair arbitration.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 21
) (
    input  logic          avr_clk,
    input  logic          avr_reset,
    sram_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_STROBE  = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;
    localparam logic [3:0] LAST      = 4'(ACCESS_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              cur_wr;
    logic              cur_avr;
    logic              grant_avr;
    logic              grant_any;
    logic              grant_wr;
    logic [ADDR_W-1:0] win_addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_avr_next;

    always_comb grant_avr = bus.avr_req && (!bus.snes_req || rr_avr_next);

    // Pointer follows every grant, so a lone request also counts as a turn.
    always_ff @(posedge avr_clk) begin
        if (avr_reset)
            rr_avr_next <= 1'b0;
        else if (state == S_IDLE && grant_any)
            rr_avr_next <= !grant_avr;
    end
`else
    always_comb grant_avr = bus.avr_req && !bus.snes_req;
`endif

    always_comb begin
        grant_any = bus.avr_req || bus.snes_req;
        grant_wr  = grant_avr && bus.avr_wr;
        win_addr  = grant_avr ? bus.avr_addr : bus.snes_addr;
    end

    always_ff @(posedge avr_clk) begin
        if (avr_reset) begin
            state            <= S_IDLE;
            cnt              <= 4'd0;
            cur_wr           <= 1'b0;
            cur_avr          <= 1'b0;
            bus.sram_addr    <= '0;
            bus.sram_dout    <= 8'h00;
            bus.sram_dout_en <= 1'b0;
            bus.sram_ce_n    <= 1'b1;
            bus.sram_oe_n    <= 1'b1;
            bus.sram_we_n    <= 1'b1;
            bus.avr_ack      <= 1'b0;
            bus.snes_ack     <= 1'b0;
            bus.avr_rdata    <= 8'h00;
            bus.snes_rdata   <= 8'h00;
        end else begin
            bus.avr_ack  <= 1'b0;
            bus.snes_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        state            <= S_SETUP;
                        cur_avr          <= grant_avr;
                        cur_wr           <= grant_wr;
                        bus.sram_addr    <= win_addr;
                        bus.sram_ce_n    <= 1'b0;
                        bus.sram_dout_en <= grant_wr;
                        if (grant_wr)
                            bus.sram_dout <= bus.avr_wdata;
                    end
                end
                S_SETUP: begin
                    state         <= S_STROBE;
                    cnt           <= 4'd0;
                    bus.sram_oe_n <= cur_wr;
                    bus.sram_we_n <= !cur_wr;
                end
                S_STROBE: begin
                    if (cnt == LAST) begin
                        state            <= S_RELEASE;
                        bus.sram_ce_n    <= 1'b1;
                        bus.sram_oe_n    <= 1'b1;
                        bus.sram_we_n    <= 1'b1;
                        bus.sram_dout_en <= 1'b0;
                        bus.avr_ack      <= cur_avr;
                        bus.snes_ack     <= !cur_avr;
                        // Data is sampled on the edge that closes the strobe window.
                        if (!cur_wr) begin
                            if (cur_avr) bus.avr_rdata  <= bus.sram_din;
                            else         bus.snes_rdata <= bus.sram_din;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RELEASE: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: table-driven single accesses checked cycle by cycle,
// scoreboard on acks, plus arbitration, reset-abort and latency sequences.
module tb_sram_arbiter;
    localparam int AC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_arbiter_if #(.ADDR_W(21)) bus_m  ();
    sram_arbiter_if #(.ADDR_W(21)) bus_1  ();
    sram_arbiter_if #(.ADDR_W(21)) bus_15 ();

    sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(21)) dut    (.avr_clk(clk), .avr_reset(rst), .bus(bus_m));
    sram_arbiter #(.ACCESS_CYCLES(1),  .ADDR_W(21)) dut_1  (.avr_clk(clk), .avr_reset(rst), .bus(bus_1));
    sram_arbiter #(.ACCESS_CYCLES(15), .ADDR_W(21)) dut_15 (.avr_clk(clk), .avr_reset(rst), .bus(bus_15));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        snes;
        logic [7:0]  rdata;
        logic [7:0]  other;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        snes;
        logic        wr;
        logic [20:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  din;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t tbl[7];

    logic [7:0] m_avr_rd, m_snes_rd;

    // Scoreboard: every ack pops the oldest expected completion.
    sb_t e;
    always @(negedge clk) begin
        if (bus_m.avr_ack || bus_m.snes_ack) begin
            chk("ack_exclusive", {31'd0, bus_m.avr_ack & bus_m.snes_ack}, 0);
            if (sbq.size() == 0) begin
                chk("ack_expected", sbq.size(), 1);
            end else begin
                e = sbq.pop_front();
                chk("ack_who", {31'd0, bus_m.snes_ack}, {31'd0, e.snes});
                chk("rdata", e.snes ? bus_m.snes_rdata : bus_m.avr_rdata, e.rdata);
                chk("other_rdata", e.snes ? bus_m.avr_rdata : bus_m.snes_rdata, e.other);
            end
        end
    end

    task automatic push_exp(input logic snes, input logic wr, input logic [7:0] din);
        sb_t s;
        s.snes = snes;
        if (snes) begin
            m_snes_rd = din;
            s.rdata = m_snes_rd; s.other = m_avr_rd;
        end else begin
            if (!wr) m_avr_rd = din;
            s.rdata = m_avr_rd; s.other = m_snes_rd;
        end
        sbq.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        @(negedge clk); rst = 1'b0;
        m_avr_rd = 8'h00; m_snes_rd = 8'h00;
    endtask

    task automatic do_access(input vec_t v);
        logic w;
        w = !v.snes && v.wr;
        @(negedge clk);
        bus_m.sram_din = v.din;
        if (v.snes) begin
            bus_m.snes_req = 1'b1; bus_m.snes_addr = v.addr;
        end else begin
            bus_m.avr_req = 1'b1; bus_m.avr_wr = v.wr;
            bus_m.avr_addr = v.addr; bus_m.avr_wdata = v.wdata;
        end
        sbq.push_back('{v.snes, v.exp_rd, v.snes ? m_avr_rd : m_snes_rd});
        if (v.snes) m_snes_rd = v.exp_rd; else m_avr_rd = v.exp_rd;
        @(negedge clk);
        chk("setup_ce_n", {31'd0, bus_m.sram_ce_n}, 0);
        chk("setup_oe_we", {30'd0, bus_m.sram_oe_n, bus_m.sram_we_n}, 32'h3);
        chk("setup_dout_en", {31'd0, bus_m.sram_dout_en}, {31'd0, w});
        chk("setup_addr", {11'd0, bus_m.sram_addr}, {11'd0, v.addr});
        if (w) chk("setup_dout", {24'd0, bus_m.sram_dout}, {24'd0, v.wdata});
        // Inputs change after grant and the request drops; the access must carry on.
        bus_m.avr_req = 1'b0; bus_m.snes_req = 1'b0;
        bus_m.avr_addr = 21'h1FFFFF; bus_m.snes_addr = ~v.addr;
        bus_m.avr_wr = ~bus_m.avr_wr; bus_m.avr_wdata = ~v.wdata;
        for (int k = 0; k < AC; k++) begin
            @(negedge clk);
            chk("strobe_ce_n", {31'd0, bus_m.sram_ce_n}, 0);
            chk("strobe_oe_n", {31'd0, bus_m.sram_oe_n}, {31'd0, w});
            chk("strobe_we_n", {31'd0, bus_m.sram_we_n}, {31'd0, !w});
            chk("strobe_dout_en", {31'd0, bus_m.sram_dout_en}, {31'd0, w});
            chk("strobe_addr", {11'd0, bus_m.sram_addr}, {11'd0, v.addr});
        end
        @(negedge clk);
        chk("release_ack", {31'd0, v.snes ? bus_m.snes_ack : bus_m.avr_ack}, 1);
        chk("release_strobes", {29'd0, bus_m.sram_ce_n, bus_m.sram_oe_n, bus_m.sram_we_n}, 32'h7);
        chk("release_dout_en", {31'd0, bus_m.sram_dout_en}, 0);
        @(negedge clk);
        chk("idle_ack", {30'd0, bus_m.avr_ack, bus_m.snes_ack}, 0);
    endtask

    function automatic logic lat_oe(input int i);
        return (i == 0) ? bus_1.sram_oe_n : bus_15.sram_oe_n;
    endfunction
    function automatic logic lat_ce(input int i);
        return (i == 0) ? bus_1.sram_ce_n : bus_15.sram_ce_n;
    endfunction
    function automatic logic lat_ack(input int i);
        return (i == 0) ? bus_1.avr_ack : bus_15.avr_ack;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc;
        int first_ack[2], second_ack[2], oe_low[2], idle_cnt[2];
        int acs[2];
        logic rr;
        acs[0] = 1; acs[1] = 15;
`ifdef ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        tbl[0] = '{1'b0, 1'b1, 21'h12345,  8'hA5, 8'h00, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 21'h00100,  8'h00, 8'h3C, 8'h3C};
        tbl[2] = '{1'b0, 1'b0, 21'h0ABCD,  8'h00, 8'h5A, 8'h5A};
        tbl[3] = '{1'b1, 1'b0, 21'h1FFFF,  8'h00, 8'hC3, 8'hC3};
        tbl[4] = '{1'b0, 1'b1, 21'h00001,  8'hFF, 8'h11, 8'h5A};
        tbl[5] = '{1'b0, 1'b0, 21'h1FFFFF, 8'h00, 8'h96, 8'h96};
        tbl[6] = '{1'b1, 1'b0, 21'h00000,  8'h00, 8'h00, 8'h00};

        bus_m.avr_req = 0; bus_m.avr_wr = 0; bus_m.avr_addr = 0; bus_m.avr_wdata = 0;
        bus_m.snes_req = 0; bus_m.snes_addr = 0; bus_m.sram_din = 0;
        bus_1.avr_req = 0; bus_1.avr_wr = 0; bus_1.avr_addr = 21'h10; bus_1.avr_wdata = 0;
        bus_1.snes_req = 0; bus_1.snes_addr = 0; bus_1.sram_din = 8'h21;
        bus_15.avr_req = 0; bus_15.avr_wr = 0; bus_15.avr_addr = 21'h10; bus_15.avr_wdata = 0;
        bus_15.snes_req = 0; bus_15.snes_addr = 0; bus_15.sram_din = 8'h21;

        do_reset();
        chk("rst_strobes", {29'd0, bus_m.sram_ce_n, bus_m.sram_oe_n, bus_m.sram_we_n}, 32'h7);
        chk("rst_dout_en", {31'd0, bus_m.sram_dout_en}, 0);
        chk("rst_addr", {11'd0, bus_m.sram_addr}, 0);
        chk("rst_dout", {24'd0, bus_m.sram_dout}, 0);
        chk("rst_acks", {30'd0, bus_m.avr_ack, bus_m.snes_ack}, 0);
        chk("rst_rdata", {16'd0, bus_m.avr_rdata, bus_m.snes_rdata}, 0);

        foreach (tbl[i]) do_access(tbl[i]);

        // Both requesters held continuously from a fresh reset.
        do_reset();
        @(negedge clk);
        bus_m.avr_req = 1; bus_m.avr_wr = 1; bus_m.avr_addr = 21'h222; bus_m.avr_wdata = 8'h44;
        bus_m.snes_req = 1; bus_m.snes_addr = 21'h333; bus_m.sram_din = 8'h77;
        for (int i = 0; i < 4; i++) push_exp(rr ? (i % 2 == 0) : 1'b1, 1'b1, 8'h77);
        n = 0; cyc = 0;
        while (n < 4 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (bus_m.avr_ack || bus_m.snes_ack) n++;
        end
        bus_m.avr_req = 0; bus_m.snes_req = 0;
        chk("contend_grants", n, 4);
        @(negedge clk);
        chk("contend_sb_drained", sbq.size(), 0);
        repeat (3) @(negedge clk);

        // Reset during STROBE drops the write without an ack.
        @(negedge clk);
        bus_m.avr_req = 1; bus_m.avr_wr = 1; bus_m.avr_addr = 21'h555; bus_m.avr_wdata = 8'h12;
        @(negedge clk); bus_m.avr_req = 0;
        @(negedge clk);
        chk("abort_in_strobe", {31'd0, bus_m.sram_we_n}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_avr_rd = 8'h00; m_snes_rd = 8'h00;
        chk("abort_strobes", {29'd0, bus_m.sram_ce_n, bus_m.sram_oe_n, bus_m.sram_we_n}, 32'h7);
        chk("abort_dout_en", {31'd0, bus_m.sram_dout_en}, 0);
        chk("abort_ack", {31'd0, bus_m.avr_ack}, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_late_ack", sbq.size(), 0);
        do_access(tbl[2]);

        // Back-to-back reads on the 1- and 15-cycle instances.
        @(negedge clk);
        bus_1.avr_req = 1; bus_15.avr_req = 1;
        for (int i = 0; i < 2; i++) begin
            first_ack[i] = 0; second_ack[i] = 0; oe_low[i] = 0; idle_cnt[i] = 0;
        end
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (first_ack[i] == 0 && !lat_oe(i)) oe_low[i]++;
                if (first_ack[i] != 0 && second_ack[i] == 0 && lat_ce(i) && !lat_ack(i)) idle_cnt[i]++;
                if (lat_ack(i)) begin
                    if (first_ack[i] == 0) first_ack[i] = k;
                    else if (second_ack[i] == 0) second_ack[i] = k;
                end
            end
        end
        bus_1.avr_req = 0; bus_15.avr_req = 0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("lat%0d_first_ack", acs[i]), first_ack[i], acs[i] + 2);
            chk($sformatf("lat%0d_period", acs[i]), second_ack[i] - first_ack[i], acs[i] + 3);
            chk($sformatf("lat%0d_oe_low", acs[i]), oe_low[i], acs[i]);
            chk($sformatf("lat%0d_idle_gap", acs[i]), idle_cnt[i], 1);
        end
        chk("lat1_rdata", {24'd0, bus_1.avr_rdata}, 32'h21);
        chk("lat15_rdata", {24'd0, bus_15.avr_rdata}, 32'h21);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2, number of cycles the SRAM read/write strobe is held low (legal 1..15).
REQ-002 SHALL have parameter ADDR_W, default 21, SRAM address width.
REQ-003 SHALL use one clock and a synchronous active-high reset.
REQ-004 avr_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 avr_reset  input  1  synchronous active-high reset.
REQ-006 avr_req  input  1  AVR access request, level, held until avr_ack.
REQ-007 avr_wr  input  1  AVR direction: 1 write, 0 read.
REQ-008 avr_addr  input  ADDR_W  AVR target address.
REQ-009 avr_wdata  input  8  AVR write data.
REQ-010 avr_rdata  output  8  AVR read data, registered.
REQ-011 avr_ack  output  1  one-cycle completion pulse for AVR.
REQ-012 snes_req  input  1  SNES read request, level, held until snes_ack.
REQ-013 snes_addr  input  ADDR_W  SNES read address.
REQ-014 snes_rdata  output  8  SNES read data, registered.
REQ-015 snes_ack  output  1  one-cycle completion pulse for SNES.
REQ-016 sram_addr  output  ADDR_W  SRAM address, registered.
REQ-017 sram_dout  output  8  SRAM write data.
REQ-018 sram_din  input  8  SRAM read data.
REQ-019 sram_dout_en  output  1  tristate enable for sram_dout on the pad.
REQ-020 sram_ce_n / sram_oe_n / sram_we_n  output  1 each  active-low SRAM strobes, registered.

Function
REQ-021 SHALL implement FSM IDLE -> SETUP (1 cycle) -> STROBE (ACCESS_CYCLES cycles) -> RELEASE (1 cycle) -> IDLE.
REQ-022 IDLE: SHALL sample requests each edge; on any request, latch winner's address, direction and write data, enter SETUP; else remain in IDLE.
REQ-023 SETUP: sram_ce_n low, sram_oe_n/sram_we_n high, address valid; sram_dout_en high for writes only.
REQ-024 STROBE: sram_oe_n low for reads, sram_we_n low for writes; never both low; 4-bit counter times ACCESS_CYCLES.
REQ-025 Read data SHALL be captured from sram_din at the edge ending the last STROBE cycle into winner's rdata; other requester's rdata unchanged.
REQ-026 RELEASE: all strobes high, sram_dout_en low, winner's ack high for exactly this cycle.
REQ-027 Latency: ack high ACCESS_CYCLES+2 cycles after the edge that sampled the request (4 at default).
REQ-028 A request still high in IDLE after its ack SHALL be treated as a new access; back-to-back accesses from one requester SHALL be legal.
REQ-029 Request deassertion mid-access SHALL NOT abort; the access completes and ack is still pulsed.
REQ-030 Request inputs changing after grant SHALL NOT affect the access in flight.
REQ-031 SNES SHALL be read-only; no SNES path drives sram_we_n low.
REQ-032 avr_ack and snes_ack SHALL never be high in the same cycle.

Reset
REQ-033 Reset SHALL force IDLE, counter 0, sram_ce_n/oe_n/we_n = 1, sram_dout_en = 0, sram_addr = 0, sram_dout = 0, both acks 0, both rdata 0, round-robin pointer to "SNES next".
REQ-034 Reset asserted mid-access SHALL take effect at the next edge; the access is dropped without ack.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN: when defined, simultaneous requests in IDLE SHALL be granted to the requester not granted last (pointer updated per grant); when undefined, SNES SHALL always win and the pointer SHALL not exist.

Verification
REQ-036 AVR write addr 0x12345 data 0xA5, ACCESS_CYCLES=2 -> SETUP 1 cycle, sram_we_n low 2 cycles, sram_dout_en high 3 cycles, avr_ack in cycle 4, sram_oe_n stays high.
REQ-037 SNES read addr 0x00100, sram_din = 0x3C -> sram_oe_n low 2 cycles, snes_rdata = 0x3C, snes_ack in cycle 4, avr_rdata unchanged.
REQ-038 Both requests asserted same cycle, held continuously -> macro undefined: SNES granted every access, AVR starved; macro defined: grants alternate SNES, AVR, SNES, AVR.
REQ-039 AVR write, avr_reset pulsed during STROBE -> next cycle all strobes high, sram_dout_en 0, state IDLE, no avr_ack.
REQ-040 AVR read, avr_addr changed to 0x1FFFFF and avr_req dropped after grant -> sram_addr keeps latched value, avr_ack still pulsed.
REQ-041 ACCESS_CYCLES=1 and 15, repeated AVR reads -> strobe low exactly 1/15 cycles, ack at 3/17 cycles, one IDLE cycle between accesses.
